// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache write path: request/response payloads and txnid sizing.
package vector_cache_pkg;

    localparam int WB_REQ_NUM  = 8;
    localparam int TAG_NUM     = 4;
    localparam int TXNID_WIDTH = $clog2(WB_REQ_NUM) + 2;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0] txnid;
        logic [15:0]            addr;
        logic [31:0]            data;
    } wr_req_pld_t;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0] txnid;
        logic [1:0]             resp;
    } wr_resp_pld_t;

endpackage

// File: rtl/wr_req_master_encode_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer; pointer moves past the winner on advance.
module rr_arb #(
    parameter int N = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            // N is a power of two, so the index wraps naturally
            idx = ptr_q + IW'(i);
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_o     = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o = idx;
            end
        end
    end

    assign ptr_d = (adv_i && found) ? gnt_idx_o + IW'(1) : ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wr_req_master_encode.sv
// Write-request master encoder: arbitrates masters, allocates a per-master tag and stamps txnid.
// Optional macro WR_REQ_TXNID_CHK_EN adds the sticky txnid_err output for illegal releases.
module wr_req_master_encode
    import vector_cache_pkg::*;
#(
    parameter int MST_NUM = WB_REQ_NUM,
    parameter int TAG_NUM = vector_cache_pkg::TAG_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MST_NUM-1:0]                mst_req_vld,
    output logic [MST_NUM-1:0]                mst_req_rdy,
    input  wr_req_pld_t  [MST_NUM-1:0]        mst_req_pld,
    output logic                              out_req_vld,
    input  logic                              out_req_rdy,
    output wr_req_pld_t                       out_req_pld,
    input  logic [MST_NUM-1:0]                w_resp_vld,
    input  wr_resp_pld_t [MST_NUM-1:0]        w_resp_pld
`ifdef WR_REQ_TXNID_CHK_EN
    ,
    output logic                              txnid_err
`endif
);
    localparam int MW = $clog2(MST_NUM);

    logic [MST_NUM-1:0][TAG_NUM-1:0] busy_q;
    logic [MST_NUM-1:0][TAG_NUM-1:0] busy_d;
    logic [MST_NUM-1:0][TAG_NUM-1:0] rel_mask;
    logic [MST_NUM-1:0]              eligible;
    logic [MST_NUM-1:0]              gnt;
    logic [MW-1:0]                   win_idx;
    logic [1:0]                      free_tag;
    logic                            load_ok;
    logic                            accept;
    logic                            out_vld_q;
    wr_req_pld_t                     out_pld_q;
    wr_req_pld_t                     win_pld;
    logic                            unused_resp_bits;

    always_comb begin
        eligible = '0;
        for (int m = 0; m < MST_NUM; m++) begin
            eligible[m] = mst_req_vld[m] & ~(&busy_q[m]);
        end
    end

    rr_arb #(.N(MST_NUM)) u_rr_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (eligible),
        .adv_i     (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (win_idx)
    );

    assign load_ok     = ~out_vld_q | out_req_rdy;
    assign accept      = (|gnt) & load_ok & ~rst;
    assign mst_req_rdy = accept ? gnt : '0;

    always_comb begin
        free_tag = '0;
        for (int t = TAG_NUM - 1; t >= 0; t--) begin
            if (!busy_q[win_idx][t]) free_tag = 2'(t);
        end
    end

    always_comb begin
        win_pld                   = mst_req_pld[win_idx];
        win_pld.txnid             = '0;
        win_pld.txnid[1:0]        = free_tag;
        win_pld.txnid[2 +: MW]    = win_idx;
    end

    always_comb begin
        rel_mask         = '0;
        unused_resp_bits = 1'b0;
        for (int m = 0; m < MST_NUM; m++) begin
            if (w_resp_vld[m]) rel_mask[m] = TAG_NUM'(1) << w_resp_pld[m].txnid[1:0];
            unused_resp_bits ^= ^{w_resp_pld[m].txnid[TXNID_WIDTH-1:2], w_resp_pld[m].resp};
        end
    end

    // Release only clears busy tags, so an allocation in the same cycle can never collide with it
    always_comb begin
        busy_d = busy_q & ~rel_mask;
        if (accept) busy_d[win_idx][free_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            out_vld_q <= 1'b0;
            out_pld_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (load_ok) begin
                out_vld_q <= accept;
                if (accept) out_pld_q <= win_pld;
            end
        end
    end

    assign out_req_vld = out_vld_q;
    assign out_req_pld = out_pld_q;

`ifdef WR_REQ_TXNID_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (|(rel_mask & ~busy_q)) begin
            err_q <= 1'b1;
        end
    end

    assign txnid_err = err_q;
`endif

endmodule

// File: tb/tb_wr_req_master_encode.sv
// Directed self-checking bench for wr_req_master_encode (txnid_err checks only with WR_REQ_TXNID_CHK_EN).
module tb_wr_req_master_encode;
    import vector_cache_pkg::*;

    localparam int MST_NUM = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [MST_NUM-1:0]          mst_req_vld;
    logic [MST_NUM-1:0]          mst_req_rdy;
    wr_req_pld_t  [MST_NUM-1:0]  mst_req_pld;
    logic                        out_req_vld;
    logic                        out_req_rdy;
    wr_req_pld_t                 out_req_pld;
    logic [MST_NUM-1:0]          w_resp_vld;
    wr_resp_pld_t [MST_NUM-1:0]  w_resp_pld;
`ifdef WR_REQ_TXNID_CHK_EN
    logic                        txnid_err;
`endif

    int checks   = 0;
    int failures = 0;

    wr_req_master_encode #(.MST_NUM(MST_NUM)) dut (
        .clk         (clk),
        .rst         (rst),
        .mst_req_vld (mst_req_vld),
        .mst_req_rdy (mst_req_rdy),
        .mst_req_pld (mst_req_pld),
        .out_req_vld (out_req_vld),
        .out_req_rdy (out_req_rdy),
        .out_req_pld (out_req_pld),
        .w_resp_vld  (w_resp_vld),
        .w_resp_pld  (w_resp_pld)
`ifdef WR_REQ_TXNID_CHK_EN
        ,
        .txnid_err   (txnid_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_req_pld_t exp_pld(int m, logic [4:0] tx, logic [31:0] d);
        wr_req_pld_t p;
        p.txnid = tx;
        p.addr  = 16'h1000 + 16'(m);
        p.data  = d;
        return p;
    endfunction

    function automatic logic [31:0] dflt_data(int m);
        return 32'hA000_0000 + 32'(m);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mst_req_vld = 8'hFF;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h00) begin
            $display("FAIL reset_rdy actual=%h required=00", mst_req_rdy); failures++;
        end
        step(); step();
        checks++;
        if (out_req_vld !== 1'b0) begin
            $display("FAIL reset_vld actual=%b required=0", out_req_vld); failures++;
        end
        checks++;
        if (out_req_pld !== '0) begin
            $display("FAIL reset_pld actual=%h required=0", out_req_pld); failures++;
        end
        mst_req_vld = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [4:0] tx [2] = '{5'd12, 5'd13};
        out_req_rdy = 1'b1;
        mst_req_vld = 8'h08;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (mst_req_rdy !== 8'h08) begin
                $display("FAIL single_rdy%0d actual=%h required=08", i, mst_req_rdy); failures++;
            end
            step();
            checks++;
            if (out_req_vld !== 1'b1 || out_req_pld !== exp_pld(3, tx[i], dflt_data(3))) begin
                $display("FAIL single_out%0d actual=%b/%h required=1/%h", i, out_req_vld, out_req_pld,
                         exp_pld(3, tx[i], dflt_data(3))); failures++;
            end
        end
        mst_req_vld = '0;
        step();
        checks++;
        if (out_req_vld !== 1'b0) begin
            $display("FAIL single_drain actual=%b required=0", out_req_vld); failures++;
        end
    endtask

    task automatic test_rr();
        int         g  [4] = '{0, 1, 2, 0};
        logic [4:0] tx [4] = '{5'd0, 5'd4, 5'd8, 5'd1};
        mst_req_vld = 8'h07;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mst_req_rdy !== 8'(1 << g[i])) begin
                $display("FAIL rr_gnt%0d actual=%h required=%h", i, mst_req_rdy, 8'(1 << g[i])); failures++;
            end
            step();
            checks++;
            if (out_req_vld !== 1'b1 || out_req_pld !== exp_pld(g[i], tx[i], dflt_data(g[i]))) begin
                $display("FAIL rr_out%0d actual=%b/%h required=1/%h", i, out_req_vld, out_req_pld,
                         exp_pld(g[i], tx[i], dflt_data(g[i]))); failures++;
            end
        end
        mst_req_vld = '0;
        step();
    endtask

    task automatic test_full_release();
        mst_req_vld = 8'h20;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_req_pld.txnid !== 5'(20 + i)) begin
                $display("FAIL full_tx%0d actual=%0d required=%0d", i, out_req_pld.txnid, 20 + i); failures++;
            end
        end
        checks++;
        if (mst_req_rdy !== 8'h00) begin
            $display("FAIL full_rdy actual=%h required=00", mst_req_rdy); failures++;
        end
        mst_req_vld = 8'h30;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h10) begin
            $display("FAIL full_other_rdy actual=%h required=10", mst_req_rdy); failures++;
        end
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd16) begin
            $display("FAIL full_other_tx actual=%0d required=16", out_req_pld.txnid); failures++;
        end
        mst_req_vld = 8'h20;
        w_resp_vld = 8'h20;
        w_resp_pld[5].txnid = 5'd22;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h00) begin
            $display("FAIL rel_same_cycle_rdy actual=%h required=00", mst_req_rdy); failures++;
        end
        step();
        w_resp_vld = '0;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h20) begin
            $display("FAIL rel_next_rdy actual=%h required=20", mst_req_rdy); failures++;
        end
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd22) begin
            $display("FAIL rel_tag actual=%0d required=22", out_req_pld.txnid); failures++;
        end
        mst_req_vld = '0;
        step();
    endtask

    task automatic test_same_cycle();
        mst_req_vld = 8'h01;
        w_resp_vld = 8'h01;
        w_resp_pld[0].txnid = 5'd0;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h01) begin
            $display("FAIL same_rdy actual=%h required=01", mst_req_rdy); failures++;
        end
        step();
        w_resp_vld = '0;
        checks++;
        if (out_req_pld.txnid !== 5'd2) begin
            $display("FAIL same_alloc actual=%0d required=2", out_req_pld.txnid); failures++;
        end
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd0) begin
            $display("FAIL same_freed actual=%0d required=0", out_req_pld.txnid); failures++;
        end
        mst_req_vld = '0;
        step();
    endtask

    task automatic test_backpressure();
        wr_req_pld_t held;
        held = exp_pld(1, 5'd5, dflt_data(1));
        mst_req_vld = 8'h02;
        step();
        out_req_rdy = 1'b0;
        mst_req_pld[1].data = 32'hBEEF_0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_req_vld !== 1'b1 || out_req_pld !== held || mst_req_rdy !== 8'h00) begin
                $display("FAIL bp_hold%0d actual=%b/%h/%h required=1/%h/00", i, out_req_vld, out_req_pld,
                         mst_req_rdy, held); failures++;
            end
            step();
        end
        out_req_rdy = 1'b1;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h02) begin
            $display("FAIL bp_release_rdy actual=%h required=02", mst_req_rdy); failures++;
        end
        step();
        checks++;
        if (out_req_vld !== 1'b1 || out_req_pld !== exp_pld(1, 5'd6, 32'hBEEF_0001)) begin
            $display("FAIL bp_next actual=%b/%h required=1/%h", out_req_vld, out_req_pld,
                     exp_pld(1, 5'd6, 32'hBEEF_0001)); failures++;
        end
        mst_req_vld = '0;
        mst_req_pld[1].data = dflt_data(1);
        step();
    endtask

    task automatic test_bad_release();
        w_resp_vld = 8'h40;
        w_resp_pld[6].txnid = 5'd25;
        step();
        w_resp_vld = '0;
`ifdef WR_REQ_TXNID_CHK_EN
        checks++;
        if (txnid_err !== 1'b1) begin
            $display("FAIL txnid_err actual=%b required=1", txnid_err); failures++;
        end
`endif
        mst_req_vld = 8'h40;
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd24) begin
            $display("FAIL bad_rel_tag0 actual=%0d required=24", out_req_pld.txnid); failures++;
        end
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd25) begin
            $display("FAIL bad_rel_tag1 actual=%0d required=25", out_req_pld.txnid); failures++;
        end
        mst_req_vld = '0;
        step();
    endtask

    task automatic test_reset_mid();
        mst_req_vld = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_req_pld.txnid !== 5'(28 + i)) begin
                $display("FAIL rstmid_tx%0d actual=%0d required=%0d", i, out_req_pld.txnid, 28 + i); failures++;
            end
        end
        out_req_rdy = 1'b0;
        mst_req_vld = '0;
        step();
        checks++;
        if (out_req_vld !== 1'b1) begin
            $display("FAIL rstmid_pending actual=%b required=1", out_req_vld); failures++;
        end
        rst = 1'b1;
        mst_req_vld = 8'h80;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h00) begin
            $display("FAIL rstmid_rdy actual=%h required=00", mst_req_rdy); failures++;
        end
        step();
        checks++;
        if (out_req_vld !== 1'b0 || out_req_pld !== '0) begin
            $display("FAIL rstmid_out actual=%b/%h required=0/0", out_req_vld, out_req_pld); failures++;
        end
`ifdef WR_REQ_TXNID_CHK_EN
        checks++;
        if (txnid_err !== 1'b0) begin
            $display("FAIL rstmid_err actual=%b required=0", txnid_err); failures++;
        end
`endif
        rst = 1'b0;
        out_req_rdy = 1'b1;
        mst_req_vld = 8'h81;
        #1;
        checks++;
        if (mst_req_rdy !== 8'h01) begin
            $display("FAIL rstmid_ptr actual=%h required=01", mst_req_rdy); failures++;
        end
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd0) begin
            $display("FAIL rstmid_m0_tag actual=%0d required=0", out_req_pld.txnid); failures++;
        end
        mst_req_vld = 8'h80;
        step();
        checks++;
        if (out_req_pld.txnid !== 5'd28) begin
            $display("FAIL rstmid_m7_tag actual=%0d required=28", out_req_pld.txnid); failures++;
        end
        mst_req_vld = '0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        mst_req_vld = '0;
        out_req_rdy = 1'b1;
        w_resp_vld = '0;
        for (int m = 0; m < MST_NUM; m++) begin
            mst_req_pld[m].txnid = 5'h1F;
            mst_req_pld[m].addr  = 16'h1000 + 16'(m);
            mst_req_pld[m].data  = dflt_data(m);
            w_resp_pld[m].txnid  = '0;
            w_resp_pld[m].resp   = '0;
        end
        test_reset();
        test_single();
        test_rr();
        test_full_release();
        test_same_cycle();
        test_backpressure();
        test_bad_release();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
